// File: rtl/qms_pkg.sv
// Shared state encodings for the display/annunciator blocks.
package qms_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } qms_state_e;

endpackage

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle event strobes into human-visible ON periods separated by
// forced-low gaps, queueing events that arrive while a period is being rendered.
module pulse_stretcher
  import qms_pkg::*;
#(
  parameter int ON_CYCLES   = 50_000_000,
  parameter int GAP_CYCLES  = 25_000_000,
  parameter int MAX_PENDING = 7,
  localparam int PEND_W     = $clog2(MAX_PENDING + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pulse_in,
  output logic              stretched_out,
  output logic              busy_out,
  output logic [PEND_W-1:0] pending_out,
  output logic              overflow_out
);

  localparam int MAX_DUR = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;

  // The counter holds cycles remaining minus one, so a load of N-1 gives N cycles.
  localparam logic [CNT_W-1:0]  ON_LOAD   = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(MAX_PENDING);
  localparam logic [PEND_W-1:0] PEND_ZERO = {PEND_W{1'b0}};
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);

  qms_state_e        state_r;
  qms_state_e        state_next_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_next_s;
  logic [PEND_W-1:0] pend_next_s;
  logic              consume_s;
  logic              last_s;
  logic              accept_s;
  logic              overflow_next_s;

  // State, duration counter, pending counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      cnt_r         <= CNT_ZERO;
      pending_out   <= PEND_ZERO;
      stretched_out <= 1'b0;
      busy_out      <= 1'b0;
      overflow_out  <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      cnt_r         <= cnt_next_s;
      pending_out   <= pend_next_s;
      stretched_out <= (state_next_s == ON);
      busy_out      <= (state_next_s != IDLE);
      overflow_out  <= overflow_next_s;
    end
  end

  // Next-state selection; a GAP ending with queued events consumes one.
  always_comb begin
    state_next_s = state_r;
    consume_s    = 1'b0;
    last_s       = (cnt_r == CNT_ZERO);
    case (state_r)
      IDLE: begin
        if (pulse_in) state_next_s = ON;
        else          state_next_s = IDLE;
      end
      ON: begin
        if (last_s) state_next_s = GAP;
        else        state_next_s = ON;
      end
      GAP: begin
        if (last_s) begin
          if (pending_out != PEND_ZERO) begin
            state_next_s = ON;
            consume_s    = 1'b1;
          end else begin
            state_next_s = IDLE;
          end
        end else begin
          state_next_s = GAP;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Counter reload on state entry, pending-count bookkeeping and drop detection.
  always_comb begin
    cnt_next_s      = cnt_r;
    pend_next_s     = pending_out;
    overflow_next_s = 1'b0;
    // Pulses in IDLE start ON directly and never reach the queue.
    accept_s        = pulse_in && (state_r != IDLE);

    if (state_next_s != state_r) begin
      case (state_next_s)
        ON:      cnt_next_s = ON_LOAD;
        GAP:     cnt_next_s = GAP_LOAD;
        default: cnt_next_s = CNT_ZERO;
      endcase
    end else if (cnt_r != CNT_ZERO) begin
      cnt_next_s = cnt_r - CNT_ONE;
    end else begin
      cnt_next_s = cnt_r;
    end

    if (accept_s && consume_s) begin
      pend_next_s = pending_out;
    end else if (accept_s) begin
      if (pending_out == PEND_MAX) overflow_next_s = 1'b1;
      else                         pend_next_s     = pending_out + PEND_ONE;
    end else if (consume_s) begin
      pend_next_s = pending_out - PEND_ONE;
    end else begin
      pend_next_s = pending_out;
    end
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed scenarios for pulse_stretcher (ON=4, GAP=2, MAX_PENDING=3) with a per-cycle scoreboard.
module tb_pulse_stretcher;

  logic       clk = 1'b0;
  logic       rst;
  logic       pulse_in;
  logic       stretched_out;
  logic       busy_out;
  logic [1:0] pending_out;
  logic       overflow_out;

  int checks = 0;
  int errors = 0;
  int cur_scn = 0;
  int cur_cyc = 0;

  typedef struct packed {
    logic       s;
    logic       b;
    logic [1:0] p;
    logic       o;
  } exp_t;

  exp_t sb_q[$];

  pulse_stretcher #(
    .ON_CYCLES  (4),
    .GAP_CYCLES (2),
    .MAX_PENDING(3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pulse_in     (pulse_in),
    .stretched_out(stretched_out),
    .busy_out     (busy_out),
    .pending_out  (pending_out),
    .overflow_out (overflow_out)
  );

  always #5 clk = ~clk;

  function automatic logic in_rng(int c, int lo, int hi);
    return (c >= lo) && (c <= hi);
  endfunction

  function automatic logic pulse_at(int scn, int c);
    case (scn)
      0:       return c == 10;
      1:       return in_rng(c, 10, 12);
      2:       return in_rng(c, 10, 14);
      3:       return (c == 10) || (c == 11) || (c == 16);
      4:       return in_rng(c, 9, 11) || in_rng(c, 12, 20) || (c == 30);
      default: return 1'b0;
    endcase
  endfunction

  // Required outputs visible during cycle c, taken from the scenario descriptions.
  function automatic exp_t expect_at(int scn, int c);
    exp_t e;
    e = '0;
    case (scn)
      0: begin
        e.s = in_rng(c, 11, 14);
        e.b = in_rng(c, 11, 16);
      end
      1: begin
        e.s = in_rng(c, 11, 14) || in_rng(c, 17, 20) || in_rng(c, 23, 26);
        e.b = in_rng(c, 11, 28);
        e.p = (c == 12) ? 2'd1 : in_rng(c, 13, 16) ? 2'd2 : in_rng(c, 17, 22) ? 2'd1 : 2'd0;
      end
      2: begin
        e.s = in_rng(c, 11, 14) || in_rng(c, 17, 20) || in_rng(c, 23, 26) || in_rng(c, 29, 32);
        e.b = in_rng(c, 11, 34);
        e.p = (c == 12) ? 2'd1 : (c == 13) ? 2'd2 : in_rng(c, 14, 16) ? 2'd3 :
              in_rng(c, 17, 22) ? 2'd2 : in_rng(c, 23, 28) ? 2'd1 : 2'd0;
        e.o = (c == 15);
      end
      3: begin
        e.s = in_rng(c, 11, 14) || in_rng(c, 17, 20) || in_rng(c, 23, 26);
        e.b = in_rng(c, 11, 28);
        e.p = in_rng(c, 12, 22) ? 2'd1 : 2'd0;
      end
      4: begin
        if (c < 12) begin
          e.s = in_rng(c, 10, 11);
          e.b = in_rng(c, 10, 11);
          e.p = (c == 11) ? 2'd1 : 2'd0;
        end else begin
          e.s = in_rng(c, 31, 34);
          e.b = in_rng(c, 31, 36);
        end
      end
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s scn=%0d cyc=%0d observed=%0d expected=%0d", tag, cur_scn, cur_cyc, obs, exp);
    end
  endtask

  task automatic run_scn(input int scn, input int len);
    exp_t e;
    cur_scn  = scn;
    rst      = 1'b1;
    pulse_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < len; c++) begin
      @(posedge clk);
      #1;
      cur_cyc = c;
      if (scn == 4 && c == 21) rst = 1'b0;
      pulse_in = pulse_at(scn, c);
      sb_q.push_back(expect_at(scn, c));
      if (scn == 4 && c == 12) begin
        check("pend_before_rst", pending_out, 2'd2);
        #2 rst = 1'b1;
        #1;
        check("rst_async_stretched", {1'b0, stretched_out}, 2'd0);
        check("rst_async_busy", {1'b0, busy_out}, 2'd0);
        check("rst_async_pending", pending_out, 2'd0);
        check("rst_async_overflow", {1'b0, overflow_out}, 2'd0);
      end
      @(negedge clk);
      e = sb_q.pop_front();
      check("stretched", {1'b0, stretched_out}, {1'b0, e.s});
      check("busy", {1'b0, busy_out}, {1'b0, e.b});
      check("pending", pending_out, e.p);
      check("overflow", {1'b0, overflow_out}, {1'b0, e.o});
    end
    pulse_in = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    pulse_in = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_stretched", {1'b0, stretched_out}, 2'd0);
    check("reset_busy", {1'b0, busy_out}, 2'd0);
    check("reset_pending", pending_out, 2'd0);
    check("reset_overflow", {1'b0, overflow_out}, 2'd0);

    run_scn(0, 20);
    run_scn(1, 32);
    run_scn(2, 38);
    run_scn(3, 32);
    run_scn(4, 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
